// File: rtl/arm_pkg.sv
// Shared definitions for the ARM instruction-fetch stage.
// Holds the default address width, the architectural NOP encoding,
// PC arithmetic constants and the IF/ID register control encoding.
package arm_pkg;

    localparam int unsigned ADDR_W_DEFAULT = 32;
    localparam int unsigned INSTR_W        = 32;
    localparam int unsigned WORD_BYTES     = 4;
    // Offset between the fetch address and the PC value an instruction observes.
    localparam int unsigned PC_READ_OFFSET = 8;

    // MOV r0,r0 -- used as the bubble instruction.
    localparam logic [INSTR_W-1:0] ARM_NOP = 32'hE1A0_0000;

    // IF/ID register action for one cycle.
    typedef enum logic [1:0] {
        IFID_LOAD  = 2'd0,
        IFID_HOLD  = 2'd1,
        IFID_FLUSH = 2'd2
    } ifid_ctl_e;

endpackage : arm_pkg

// File: rtl/arm_fetch_stage_if.sv
// Instruction-memory read port between the fetch stage and the memory.
//   imem_addr  : word index (byte PC >> 2), driven by the fetch stage
//   imem_rdata : instruction word, combinational read of imem_addr
// Modports: master = fetch stage, slave = instruction memory.
interface arm_fetch_stage_if #(
    parameter int unsigned ADDR_W = arm_pkg::ADDR_W_DEFAULT
);

    logic [ADDR_W-3:0]               imem_addr;
    logic [arm_pkg::INSTR_W-1:0]     imem_rdata;

    modport master (
        output imem_addr,
        input  imem_rdata
    );

    modport slave (
        input  imem_addr,
        output imem_rdata
    );

endinterface : arm_fetch_stage_if

// File: rtl/arm_if_id_reg.sv
// IF/ID pipeline register.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   ctl           : LOAD captures a new instruction, HOLD keeps everything,
//                   FLUSH inserts a bubble (valid=0, instr=NOP, PCs kept)
//   instr_in      : instruction word to capture on LOAD
//   pc_in         : byte address of instr_in
//   valid         : register holds a real instruction
//   instr         : registered instruction
//   pc            : registered byte address
//   pc_plus8      : pc + 8, the PC value seen by the instruction
module arm_if_id_reg
    import arm_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  ifid_ctl_e           ctl,
    input  logic [INSTR_W-1:0]  instr_in,
    input  logic [ADDR_W-1:0]   pc_in,
    output logic                valid,
    output logic [INSTR_W-1:0]  instr,
    output logic [ADDR_W-1:0]   pc,
    output logic [ADDR_W-1:0]   pc_plus8
);

    // Pipeline register update; PCs are not touched by a flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid    <= 1'b0;
            instr    <= ARM_NOP;
            pc       <= '0;
            pc_plus8 <= ADDR_W'(PC_READ_OFFSET);
        end else begin
            unique case (ctl)
                IFID_LOAD: begin
                    valid    <= 1'b1;
                    instr    <= instr_in;
                    pc       <= pc_in;
                    pc_plus8 <= pc_in + ADDR_W'(PC_READ_OFFSET);
                end
                IFID_FLUSH: begin
                    valid <= 1'b0;
                    instr <= ARM_NOP;
                end
                default: begin
                    valid    <= valid;
                    instr    <= instr;
                    pc       <= pc;
                    pc_plus8 <= pc_plus8;
                end
            endcase
        end
    end

endmodule : arm_if_id_reg

// File: rtl/arm_fetch_stage.sv
// ARM instruction-fetch stage: owns the PC, drives the instruction-memory
// read port and fills the IF/ID register. Priority per cycle is
// reset > redirect > stall > halted > normal fetch.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   stall        : hold PC and IF/ID
//   redirect     : taken branch, PC <= word-aligned redirect_pc, IF/ID flushed
//   redirect_pc  : branch target byte address
//   imem         : instruction-memory read port (master side)
//   pc           : current fetch PC (byte address)
//   id_valid     : IF/ID holds a real instruction
//   id_instr     : registered instruction
//   id_pc        : byte address of id_instr
//   id_pc_plus8  : id_pc + 8
//   halted       : combinational, pc is at or past the end of instruction memory
module arm_fetch_stage
    import arm_pkg::*;
#(
    parameter int unsigned      INS_MEM_SIZE = 32,
    parameter int unsigned      ADDR_W       = ADDR_W_DEFAULT,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                redirect,
    input  logic [ADDR_W-1:0]   redirect_pc,
    arm_fetch_stage_if.master   imem,
    output logic [ADDR_W-1:0]   pc,
    output logic                id_valid,
    output logic [INSTR_W-1:0]  id_instr,
    output logic [ADDR_W-1:0]   id_pc,
    output logic [ADDR_W-1:0]   id_pc_plus8,
    output logic                halted
);

    localparam logic [ADDR_W-1:0] FETCH_LIMIT = ADDR_W'(INS_MEM_SIZE * WORD_BYTES);
    localparam logic [ADDR_W-1:0] PC_STEP     = ADDR_W'(WORD_BYTES);
    localparam logic [ADDR_W-1:0] ALIGN_MASK  = ~ADDR_W'(WORD_BYTES - 1);

    logic [ADDR_W-1:0] pc_next;
    ifid_ctl_e         ifid_ctl;

    assign halted         = (pc >= FETCH_LIMIT);
    assign imem.imem_addr = pc[ADDR_W-1:2];

    // Next PC and IF/ID action, in priority order below reset.
    always_comb begin
        pc_next  = pc + PC_STEP;
        ifid_ctl = IFID_LOAD;
        if (redirect) begin
            pc_next  = redirect_pc & ALIGN_MASK;
            ifid_ctl = IFID_FLUSH;
        end else if (stall) begin
            pc_next  = pc;
            ifid_ctl = IFID_HOLD;
        end else if (halted) begin
            pc_next  = pc;
            ifid_ctl = IFID_FLUSH;
        end
    end

    // Program counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

    arm_if_id_reg #(
        .ADDR_W (ADDR_W)
    ) u_if_id (
        .clk      (clk),
        .rst      (rst),
        .ctl      (ifid_ctl),
        .instr_in (imem.imem_rdata),
        .pc_in    (pc),
        .valid    (id_valid),
        .instr    (id_instr),
        .pc       (id_pc),
        .pc_plus8 (id_pc_plus8)
    );

endmodule : arm_fetch_stage

// File: tb/tb_arm_fetch_stage.sv
// Self-checking bench for arm_fetch_stage: directed vector table, hand
// sequences for halt/resume, then randomized traffic against a behavioural model.
module tb_arm_fetch_stage;
    import arm_pkg::*;

    localparam int unsigned AW    = 32;
    localparam int unsigned DEPTH = 32;
    localparam logic [31:0] LIMIT = 32'd128;
    localparam logic [31:0] OOR   = 32'hBAD0_0BAD;

    logic        clk = 1'b0;
    logic        rst, stall, redirect;
    logic [31:0] redirect_pc;
    logic [31:0] pc, id_instr, id_pc, id_pc_plus8;
    logic        id_valid, halted;
    logic [31:0] mem [DEPTH];

    arm_fetch_stage_if #(.ADDR_W(AW)) imem_bus ();

    assign imem_bus.imem_rdata = (imem_bus.imem_addr < 30'(DEPTH)) ?
                                 mem[imem_bus.imem_addr[4:0]] : OOR;

    arm_fetch_stage #(
        .INS_MEM_SIZE (DEPTH),
        .ADDR_W       (AW),
        .RESET_PC     (32'h0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (imem_bus.master),
        .pc          (pc),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .id_pc_plus8 (id_pc_plus8),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model of the stage, straight from the fetch rules.
    logic [31:0] m_pc, m_instr, m_idpc, m_p8;
    logic        m_valid;

    function automatic logic [31:0] mem_read(input logic [31:0] byte_addr);
        logic [31:0] idx;
        idx = byte_addr / 4;
        return (idx < DEPTH) ? mem[idx[4:0]] : OOR;
    endfunction

    task automatic mdl_step(input logic r, input logic s, input logic rd, input logic [31:0] rpc);
        if (r) begin
            m_pc = 0; m_valid = 0; m_instr = ARM_NOP; m_idpc = 0; m_p8 = 8;
        end else if (rd) begin
            m_pc = rpc - (rpc % 4); m_valid = 0; m_instr = ARM_NOP;
        end else if (s) begin
            // everything holds
        end else if (m_pc >= LIMIT) begin
            m_valid = 0; m_instr = ARM_NOP;
        end else begin
            m_instr = mem_read(m_pc); m_idpc = m_pc; m_p8 = m_pc + 8;
            m_valid = 1; m_pc = m_pc + 4;
        end
    endtask

    task automatic compare_model(input string tag);
        check({tag, ".pc"},          pc,                        m_pc);
        check({tag, ".halted"},      32'(halted),               32'(m_pc >= LIMIT));
        check({tag, ".id_valid"},    32'(id_valid),             32'(m_valid));
        check({tag, ".id_instr"},    id_instr,                  m_instr);
        check({tag, ".id_pc"},       id_pc,                     m_idpc);
        check({tag, ".id_pc_plus8"}, id_pc_plus8,               m_p8);
        check({tag, ".imem_addr"},   32'(imem_bus.imem_addr),   m_pc / 4);
    endtask

    // Drive one cycle, advance the model, sample 1 time unit after the edge.
    task automatic apply(input logic r, input logic s, input logic rd, input logic [31:0] rpc,
                         input string tag);
        rst = r; stall = s; redirect = rd; redirect_pc = rpc;
        mdl_step(r, s, rd, rpc);
        @(posedge clk);
        #1;
        compare_model(tag);
    endtask

    typedef struct {
        logic        rst, stall, redirect;
        logic [31:0] rpc;
        logic [31:0] e_pc;
        logic        e_valid;
        logic [31:0] e_instr, e_idpc, e_p8;
        logic        e_halted;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic s, input logic rd, input logic [31:0] rpc,
                                input logic [31:0] epc, input logic ev, input logic [31:0] ei,
                                input logic [31:0] eidpc, input logic [31:0] ep8);
        vec_t v;
        v.rst = r; v.stall = s; v.redirect = rd; v.rpc = rpc;
        v.e_pc = epc; v.e_valid = ev; v.e_instr = ei; v.e_idpc = eidpc; v.e_p8 = ep8;
        v.e_halted = 1'b0;
        return v;
    endfunction

    vec_t tbl [19];

    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        for (int k = 0; k < int'(DEPTH); k++) mem[k] = 32'(k + 1);
        m_pc = 0; m_valid = 0; m_instr = ARM_NOP; m_idpc = 0; m_p8 = 8;

        // reset, free run, 3-cycle stall at 0x10, redirect+stall at 0x20, reset at 0x40
        tbl[0]  = mk(1, 0, 0, 0,     32'h00, 0, ARM_NOP, 32'h00, 32'h08);
        tbl[1]  = mk(0, 0, 0, 0,     32'h04, 1, 1,       32'h00, 32'h08);
        tbl[2]  = mk(0, 0, 0, 0,     32'h08, 1, 2,       32'h04, 32'h0C);
        tbl[3]  = mk(0, 0, 0, 0,     32'h0C, 1, 3,       32'h08, 32'h10);
        tbl[4]  = mk(0, 0, 0, 0,     32'h10, 1, 4,       32'h0C, 32'h14);
        tbl[5]  = mk(0, 1, 0, 0,     32'h10, 1, 4,       32'h0C, 32'h14);
        tbl[6]  = mk(0, 1, 0, 0,     32'h10, 1, 4,       32'h0C, 32'h14);
        tbl[7]  = mk(0, 1, 0, 0,     32'h10, 1, 4,       32'h0C, 32'h14);
        tbl[8]  = mk(0, 0, 0, 0,     32'h14, 1, 5,       32'h10, 32'h18);
        tbl[9]  = mk(0, 0, 0, 0,     32'h18, 1, 6,       32'h14, 32'h1C);
        tbl[10] = mk(0, 0, 0, 0,     32'h1C, 1, 7,       32'h18, 32'h20);
        tbl[11] = mk(0, 0, 0, 0,     32'h20, 1, 8,       32'h1C, 32'h24);
        tbl[12] = mk(0, 1, 1, 32'h2E, 32'h2C, 0, ARM_NOP, 32'h1C, 32'h24);
        tbl[13] = mk(0, 0, 0, 0,     32'h30, 1, 12,      32'h2C, 32'h34);
        tbl[14] = mk(0, 0, 0, 0,     32'h34, 1, 13,      32'h30, 32'h38);
        tbl[15] = mk(0, 0, 0, 0,     32'h38, 1, 14,      32'h34, 32'h3C);
        tbl[16] = mk(0, 0, 0, 0,     32'h3C, 1, 15,      32'h38, 32'h40);
        tbl[17] = mk(0, 0, 0, 0,     32'h40, 1, 16,      32'h3C, 32'h44);
        tbl[18] = mk(1, 0, 0, 0,     32'h00, 0, ARM_NOP, 32'h00, 32'h08);

        for (int i = 0; i < 19; i++) begin
            rst = tbl[i].rst; stall = tbl[i].stall;
            redirect = tbl[i].redirect; redirect_pc = tbl[i].rpc;
            mdl_step(tbl[i].rst, tbl[i].stall, tbl[i].redirect, tbl[i].rpc);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d.pc", i),          pc,               tbl[i].e_pc);
            check($sformatf("vec%0d.id_valid", i),    32'(id_valid),    32'(tbl[i].e_valid));
            check($sformatf("vec%0d.id_instr", i),    id_instr,         tbl[i].e_instr);
            check($sformatf("vec%0d.id_pc", i),       id_pc,            tbl[i].e_idpc);
            check($sformatf("vec%0d.id_pc_plus8", i), id_pc_plus8,      tbl[i].e_p8);
            check($sformatf("vec%0d.halted", i),      32'(halted),      32'(tbl[i].e_halted));
        end

        // Free-run to the end of memory (bounded), then confirm the PC parks there.
        for (int i = 0; i < 64 && pc != LIMIT; i++) apply(0, 0, 0, 0, "run");
        check("halt.pc_reached", pc, 32'h80);
        for (int i = 0; i < 4; i++) begin
            apply(0, 0, 0, 0, "halted");
            check("halt.pc_hold",  pc,            32'h80);
            check("halt.flag",     32'(halted),   32'd1);
            check("halt.bubble",   32'(id_valid), 32'd0);
        end

        // Redirect out of halt, then resume fetching.
        apply(0, 0, 1, 32'h04, "resume_redir");
        check("resume.pc",     pc,            32'h04);
        check("resume.halted", 32'(halted),   32'd0);
        check("resume.valid",  32'(id_valid), 32'd0);
        apply(0, 0, 0, 0, "resume_fetch");
        check("resume.id_pc",    id_pc,         32'h04);
        check("resume.id_instr", id_instr,      32'd2);
        check("resume.id_valid", 32'(id_valid), 32'd1);

        // Reset arriving with stall and redirect both asserted.
        apply(0, 1, 0, 0, "pre_rst_stall");
        apply(1, 1, 1, 32'h50, "rst_over_all");
        check("rst_over_all.pc", pc, 32'h0);

        // Randomized traffic with random memory contents.
        for (int k = 0; k < int'(DEPTH); k++) mem[k] = $urandom;
        for (int i = 0; i < 800; i++) begin
            logic r, s, rd;
            logic [31:0] rpc;
            r   = ($urandom_range(0, 99) < 2);
            s   = ($urandom_range(0, 99) < 15);
            rd  = ($urandom_range(0, 99) < 8);
            rpc = 32'($urandom_range(0, 32'h9F));
            apply(r, s, rd, rpc, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_arm_fetch_stage
